i2c_slave_regfile: RTL and testbench

- Register map that sits directly behind I2C_SLAVE and consumes its byte-level handshake.
- Master-written bytes arrive on datareceive/received and are decoded as pointer-then-data.
- Bytes for master reads are presented on datasend and advanced on each sended strobe.
- Local logic (e.g. the BMP180 sequencer) loads measurement and ID bytes into read-only registers; I2C-writable registers are exported as control outputs.

---
 rtl/i2c_regfile_pkg.sv | 25 ++
 rtl/i2c_regfile_ptr_fsm.sv | 80 ++++++++
 rtl/i2c_slave_regfile.sv | 141 ++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regfile_pkg.sv
// Shared types and constants for the I2C slave register file.
package i2c_regfile_pkg;

  // Byte-handshake decoder states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    DATA = 2'd2
  } regfile_state_t;

  // Default geometry and identity
  localparam int         DEF_DEPTH    = 16;
  localparam int         DEF_RO_COUNT = 8;
  localparam logic [7:0] DEF_CHIP_ID  = 8'h55;

  // Register map
  localparam int REG_ID         = 0;
  localparam int REG_TEMP_MSB   = 1;
  localparam int REG_TEMP_LSB   = 2;
  localparam int REG_PRESS_MSB  = 3;
  localparam int REG_PRESS_LSB  = 4;
  localparam int REG_PRESS_XLSB = 5;
  localparam int REG_CTRL       = DEF_RO_COUNT;

endpackage

// File: rtl/i2c_regfile_ptr_fsm.sv
// Pointer-then-data decoder: tracks the transaction phase and the register
// pointer, and flags the cycle in which a master data byte is to be written.
module i2c_regfile_ptr_fsm
  import i2c_regfile_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_start,
  input  logic              bus_stop,
  input  logic              received,
  input  logic              sended,
  input  logic [ADDR_W-1:0] ptr_load,
  output logic [ADDR_W-1:0] ptr,
  output logic              i2c_wr
);

  regfile_state_t    state_r, state_nxt_s;
  logic [ADDR_W-1:0] ptr_r, ptr_nxt_s;
  logic [ADDR_W-1:0] ptr_inc_s;

  assign ptr_inc_s = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};  // wraps DEPTH-1 -> 0
  assign ptr       = ptr_r;

  // State and pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ptr_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Next state, next pointer and write request; bus_start outranks any byte
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    i2c_wr      = 1'b0;
    if (bus_start) begin
      state_nxt_s = PTR;
    end else if (bus_stop) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        PTR: begin
          if (received) begin
            ptr_nxt_s   = ptr_load;
            state_nxt_s = DATA;
          end else if (sended) begin
            ptr_nxt_s   = ptr_inc_s;
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = PTR;
          end
        end
        DATA: begin
          // received wins over a simultaneous sended; pointer moves once
          if (received) begin
            i2c_wr    = 1'b1;
            ptr_nxt_s = ptr_inc_s;
          end else if (sended) begin
            ptr_nxt_s = ptr_inc_s;
          end else begin
            ptr_nxt_s = ptr_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// Register file behind I2C_SLAVE: RO block loaded locally, RW block written
// by the master and exported as ctrl_regs. Define REGFILE_SHADOW_EN to make
// master reads of RO registers return a snapshot taken at bus_start.
module i2c_slave_regfile
  import i2c_regfile_pkg::*;
#(
  parameter int         DEPTH    = DEF_DEPTH,
  parameter int         RO_COUNT = DEF_RO_COUNT,
  parameter logic [7:0] CHIP_ID  = DEF_CHIP_ID,
  parameter int         ADDR_W   = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bus_start,
  input  logic                          bus_stop,
  input  logic [7:0]                    datareceive,
  input  logic                          received,
  output logic [7:0]                    datasend,
  input  logic                          sended,
  input  logic                          upd_valid,
  input  logic [ADDR_W-1:0]             upd_addr,
  input  logic [7:0]                    upd_data,
  output logic [8*(DEPTH-RO_COUNT)-1:0] ctrl_regs,
  output logic                          wr_strobe,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [ADDR_W-1:0]             ptr
);

  localparam logic [ADDR_W:0] RO_LIM = (ADDR_W+1)'(RO_COUNT);

  logic [7:0]        regs_r [DEPTH];
  logic [ADDR_W-1:0] ptr_s;
  logic              i2c_wr_s;
  logic              i2c_wr_ok_s;
  logic [7:0]        rd_byte_s;
  logic [7:0]        datasend_r;
  logic              wr_strobe_r;
  logic [ADDR_W-1:0] wr_addr_r;

  i2c_regfile_ptr_fsm #(.ADDR_W(ADDR_W)) u_ptr_fsm (
    .clk       (clk),
    .reset     (reset),
    .bus_start (bus_start),
    .bus_stop  (bus_stop),
    .received  (received),
    .sended    (sended),
    .ptr_load  (datareceive[ADDR_W-1:0]),
    .ptr       (ptr_s),
    .i2c_wr    (i2c_wr_s)
  );

  // Master writes to the RO block are dropped silently
  always_comb begin
    i2c_wr_ok_s = 1'b0;
    if (i2c_wr_s && ({1'b0, ptr_s} >= RO_LIM)) begin
      i2c_wr_ok_s = 1'b1;
    end else begin
      i2c_wr_ok_s = 1'b0;
    end
  end

  // Register array: master write beats a local update to the same RW address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= (i == 0) ? CHIP_ID : 8'h00;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i2c_wr_ok_s && (ptr_s == ADDR_W'(i))) begin
          regs_r[i] <= datareceive;
        end else if (upd_valid && (upd_addr == ADDR_W'(i))) begin
          regs_r[i] <= upd_data;
        end
      end
    end
  end

`ifdef REGFILE_SHADOW_EN
  logic [7:0] shadow_r [RO_COUNT];

  // Snapshot of the RO block taken at every START for coherent multi-byte reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RO_COUNT; i++) begin
        shadow_r[i] <= (i == 0) ? CHIP_ID : 8'h00;
      end
    end else if (bus_start) begin
      for (int i = 0; i < RO_COUNT; i++) begin
        shadow_r[i] <= regs_r[i];
      end
    end
  end

  // Read mux: RO addresses come from the snapshot
  always_comb begin
    rd_byte_s = regs_r[ptr_s];
    for (int i = 0; i < RO_COUNT; i++) begin
      if (ptr_s == ADDR_W'(i)) begin
        rd_byte_s = shadow_r[i];
      end else begin
        rd_byte_s = rd_byte_s;
      end
    end
  end
`else
  // Read mux: live array
  always_comb begin
    rd_byte_s = regs_r[ptr_s];
  end
`endif

  // Registered read byte and write notification
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      datasend_r  <= CHIP_ID;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
    end else begin
      datasend_r  <= rd_byte_s;
      wr_strobe_r <= i2c_wr_ok_s;
      if (i2c_wr_ok_s) begin
        wr_addr_r <= ptr_s;
      end
    end
  end

  // Flattened view of the RW block, lowest RW register in the LSB byte
  always_comb begin
    ctrl_regs = '0;
    for (int j = 0; j < DEPTH - RO_COUNT; j++) begin
      ctrl_regs[8*j +: 8] = regs_r[RO_COUNT + j];
    end
  end

  assign datasend  = datasend_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign ptr       = ptr_s;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed self-checking bench for i2c_slave_regfile (default parameters).
module tb_i2c_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_start = 1'b0;
  logic        bus_stop = 1'b0;
  logic [7:0]  datareceive = 8'h00;
  logic        received = 1'b0;
  logic [7:0]  datasend;
  logic        sended = 1'b0;
  logic        upd_valid = 1'b0;
  logic [3:0]  upd_addr = 4'h0;
  logic [7:0]  upd_data = 8'h00;
  logic [63:0] ctrl_regs;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic [3:0]  ptr;

  int checks = 0;
  int errors = 0;

  i2c_slave_regfile dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus_start   (bus_start),
    .bus_stop    (bus_stop),
    .datareceive (datareceive),
    .received    (received),
    .datasend    (datasend),
    .sended      (sended),
    .upd_valid   (upd_valid),
    .upd_addr    (upd_addr),
    .upd_data    (upd_data),
    .ctrl_regs   (ctrl_regs),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .ptr         (ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    bus_start = 1'b1; tick(); bus_start = 1'b0;
  endtask

  task automatic do_stop();
    bus_stop = 1'b1; tick(); bus_stop = 1'b0;
  endtask

  task automatic do_recv(input logic [7:0] d);
    datareceive = d; received = 1'b1; tick(); received = 1'b0;
  endtask

  task automatic do_send();
    sended = 1'b1; tick(); sended = 1'b0;
  endtask

  task automatic do_upd(input logic [3:0] a, input logic [7:0] d);
    upd_addr = a; upd_data = d; upd_valid = 1'b1; tick(); upd_valid = 1'b0;
  endtask

  initial begin
    // Reset
    #12;
    check("rst_ptr", 64'(ptr), 64'h0);
    check("rst_datasend", 64'(datasend), 64'h55);
    check("rst_wr_strobe", 64'(wr_strobe), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    check("rst_ctrl", ctrl_regs, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // First read without pointer write returns the chip ID
    do_start(); tick();
    check("rd0_datasend", 64'(datasend), 64'h55);
    do_send();
    check("rd0_ptr", 64'(ptr), 64'h1);
    do_stop();

    // IDLE ignores bytes
    do_recv(8'h33);
    check("idle_ptr", 64'(ptr), 64'h1);
    check("idle_strobe", 64'(wr_strobe), 64'h0);

    // Pointer then two data writes to RW registers
    do_start();
    do_recv(8'h08);
    check("wr_ptr8", 64'(ptr), 64'h8);
    check("wr_ptr8_nostrobe", 64'(wr_strobe), 64'h0);
    do_recv(8'hA5);
    check("wr_a5_strobe", 64'(wr_strobe), 64'h1);
    check("wr_a5_addr", 64'(wr_addr), 64'h8);
    do_recv(8'h3C);
    check("wr_3c_strobe", 64'(wr_strobe), 64'h1);
    check("wr_3c_addr", 64'(wr_addr), 64'h9);
    tick();
    check("wr_strobe_drop", 64'(wr_strobe), 64'h0);
    check("wr_ctrl", 64'(ctrl_regs[15:0]), 64'h3CA5);
    do_stop();

    // Write to RO register dropped
    do_start();
    do_recv(8'h01);
    do_recv(8'hFF);
    check("ro_nostrobe", 64'(wr_strobe), 64'h0);
    check("ro_ptr", 64'(ptr), 64'h2);
    do_stop();
    do_start(); do_recv(8'h01); tick(); tick();
    check("ro_unchanged", 64'(datasend), 64'h00);
    do_stop();

    // Local updates, then repeated-start read
    do_upd(4'h1, 8'h12);
    do_upd(4'h2, 8'h34);
    do_start(); do_recv(8'h01); do_start(); tick();
    check("upd_rd1", 64'(datasend), 64'h12);
    do_send(); tick();
    check("upd_rd2", 64'(datasend), 64'h34);
    check("upd_ptr", 64'(ptr), 64'h2);
    do_send();
    check("upd_ptr3", 64'(ptr), 64'h3);
    do_stop();

    // Wrap on write: reg15 then pointer rolls to 0
    do_start(); do_recv(8'h0F); do_recv(8'h77);
    check("wrap_wr_addr", 64'(wr_addr), 64'hF);
    check("wrap_wr_ptr", 64'(ptr), 64'h0);
    check("wrap_ctrl", 64'(ctrl_regs[63:56]), 64'h77);
    do_stop();

    // Wrap on read: reg15, reg0, reg1
    do_start(); do_recv(8'h0F); do_start(); tick();
    check("wrap_rd15", 64'(datasend), 64'h77);
    do_send(); tick();
    check("wrap_rd0", 64'(datasend), 64'h55);
    check("wrap_rd_ptr0", 64'(ptr), 64'h0);
    do_send(); tick();
    check("wrap_rd1", 64'(datasend), 64'h12);
    do_stop();

    // Pointer byte upper bits discarded
    do_start(); do_recv(8'h1F);
    check("ptr_mod", 64'(ptr), 64'hF);
    do_stop();

    // Collision on RW register: I2C write wins
    do_start(); do_recv(8'h09);
    upd_addr = 4'h9; upd_data = 8'h11; upd_valid = 1'b1;
    datareceive = 8'h22; received = 1'b1;
    tick();
    upd_valid = 1'b0; received = 1'b0;
    check("coll_rw_strobe", 64'(wr_strobe), 64'h1);
    check("coll_rw_val", 64'(ctrl_regs[15:8]), 64'h22);
    do_stop();

    // Collision on RO register: local update wins
    do_start(); do_recv(8'h02);
    upd_addr = 4'h2; upd_data = 8'h66; upd_valid = 1'b1;
    datareceive = 8'h99; received = 1'b1;
    tick();
    upd_valid = 1'b0; received = 1'b0;
    check("coll_ro_nostrobe", 64'(wr_strobe), 64'h0);
    do_stop();
    do_start(); do_recv(8'h02); do_start(); tick();
    check("coll_ro_val", 64'(datasend), 64'h66);
    do_stop();

    // Simultaneous received and sended: write happens, pointer moves once
    do_start(); do_recv(8'h0A);
    datareceive = 8'h5A; received = 1'b1; sended = 1'b1;
    tick();
    received = 1'b0; sended = 1'b0;
    check("both_ptr", 64'(ptr), 64'hB);
    check("both_val", 64'(ctrl_regs[23:16]), 64'h5A);
    do_stop();

    // bus_start with a byte: byte ignored
    do_start(); do_recv(8'h0C);
    datareceive = 8'hEE; received = 1'b1; bus_start = 1'b1;
    tick();
    received = 1'b0; bus_start = 1'b0;
    check("start_wins_ptr", 64'(ptr), 64'hC);
    check("start_wins_nostrobe", 64'(wr_strobe), 64'h0);
    check("start_wins_ctrl", 64'(ctrl_regs[39:32]), 64'h00);
    do_stop();

    // Local update during a read of an RO register
    do_start(); do_recv(8'h01); do_stop();
    do_upd(4'h1, 8'hAA);
    do_start(); tick();
    do_upd(4'h1, 8'hBB); tick(); tick();
`ifdef REGFILE_SHADOW_EN
    check("shadow_hold", 64'(datasend), 64'hAA);
`else
    check("live_read", 64'(datasend), 64'hBB);
`endif
    do_start(); tick(); tick();
    check("restart_read", 64'(datasend), 64'hBB);
    do_stop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
